// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver.
//
// Decodes frames of: start bit (0), DATA_WIDTH data bits LSB first, one
// even-parity bit (XOR of the data bits), and one stop bit (1). Each bit is
// sampled at mid-bit using a sample_tick strobe that runs at OVERSAMPLE x baud.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   sample_tick  one-clk strobe at OVERSAMPLE x baud; all state advances only on it
//   rx_serial    asynchronous serial line, idles high
//   data_out     last received word, held until the next frame completes
//   data_valid   one-clk pulse when a frame completes
//   parity_err   received parity bit differs from XOR of data_out (held with data_out)
//   frame_err    stop bit sampled as 0 (held with data_out)
//   busy         high whenever the receiver is not in IDLE
//
// Output handshake: there is no back-pressure. data_valid is a one-cycle
// strobe; data_out/parity_err/frame_err are updated on the same edge that
// raises it and stay stable until the next strobe. A consumer that misses the
// strobe loses the frame.

module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4,
    WAIT_IDLE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_s;
  logic                  bit_end;

  // Two-flop synchronizer; resets to the idle (high) line level so reset
  // release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s    = sync2_q;
  // Last tick of a full bit period, measured from the previous mid-bit sample.
  assign bit_end = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (sample_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START_BIT;
            tick_cnt_d = '0;
          end
        end

        START_BIT: begin
          if (tick_cnt_q == TICK_MID) begin
            // Mid start bit: a line that is high again was only a glitch.
            if (!rx_s) begin
              state_d    = DATA_BITS;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        DATA_BITS: begin
          if (bit_end) begin
            tick_cnt_d         = '0;
            shift_d[bit_cnt_q] = rx_s;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = PARITY_BIT;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        PARITY_BIT: begin
          if (bit_end) begin
            tick_cnt_d = '0;
            par_bit_d  = rx_s;
            state_d    = STOP_BIT;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        STOP_BIT: begin
          if (bit_end) begin
            tick_cnt_d   = '0;
            data_out_d   = shift_q;
            parity_err_d = par_bit_q ^ (^shift_q);
            frame_err_d  = ~rx_s;
            data_valid_d = 1'b1;
            // Leaving at mid stop bit lets a back-to-back start be caught.
            state_d      = rx_s ? IDLE : WAIT_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with default parameters (8 data bits, 16x
// oversampling) and a sample_tick every 4 clk.

module tb_uart_rx;

  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  // Stop sample is 168 ticks after start detection; data_valid rises on the
  // edge of that tick, busy rose on the edge of the detection tick.
  localparam int DV_LATENCY_CLK = 168 * TICK_DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic          rx_serial;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Expected frames: {frame_err, parity_err, data}
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] mon_e;

  int   cyc           = 0;
  int   busy_rise_cyc = 0;
  int   busy_cycles   = 0;
  int   dv_count      = 0;
  logic busy_prev     = 1'b0;

  uart_rx #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx_serial  (rx_serial),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // ---------------- clock / tick / reset ----------------
  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cycles++;
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      busy_prev = busy;
      if (data_valid) begin
        dv_count++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_dv", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("data_out",   data_out,   mon_e[DW-1:0]);
          check_eq("parity_err", parity_err, mon_e[DW]);
          check_eq("frame_err",  frame_err,  mon_e[DW+1]);
          check_eq("dv_latency", cyc - busy_rise_cyc, DV_LATENCY_CLK);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sample_tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_serial = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic wait_dv(input int target);
    for (int i = 0; i < 2000 && dv_count < target; i++) @(negedge clk);
    check_eq("dv_count", dv_count, target);
  endtask

  task automatic check_outputs_zero(input string tag);
    #1;
    check_eq({tag, "_data_out"},   data_out,   32'h0);
    check_eq({tag, "_data_valid"}, data_valid, 32'h0);
    check_eq({tag, "_parity_err"}, parity_err, 32'h0);
    check_eq({tag, "_frame_err"},  frame_err,  32'h0);
    check_eq({tag, "_busy"},       busy,       32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst       = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(2 * OS);

    // Clean 0xA5 frame, also checks the 672-clk start-to-valid latency.
    exp_q.push_back({1'b0, 1'b0, 8'hA5});
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_dv(1);
    send_bit(1'b1);

    // Odd data, back to back with no idle gap.
    exp_q.push_back({1'b0, 1'b0, 8'h01});
    exp_q.push_back({1'b0, 1'b0, 8'h80});
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    wait_dv(3);
    send_bit(1'b1);

    // Parity error, then a clean frame clears it.
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_dv(4);
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    send_frame(8'h00, 1'b0, 1'b1);
    wait_dv(5);
    send_bit(1'b1);

    // Framing error followed by a 3-bit break, then a normal frame.
    exp_q.push_back({1'b1, 1'b0, 8'h55});
    send_frame(8'h55, 1'b0, 1'b0);
    wait_dv(6);
    wait_ticks(3 * OS);
    check_eq("break_busy", busy, 32'h1);
    check_eq("break_no_frame", dv_count, 32'd6);
    @(negedge clk);
    rx_serial = 1'b1;
    wait_ticks(2 * OS);
    check_eq("break_release_idle", busy, 32'h0);
    exp_q.push_back({1'b0, 1'b0, 8'h0F});
    send_frame(8'h0F, 1'b0, 1'b1);
    wait_dv(7);
    send_bit(1'b1);

    // Start glitch: 4 ticks low; busy lasts exactly the 8 ticks to mid-start.
    @(negedge clk);
    busy_cycles = 0;
    rx_serial   = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx_serial = 1'b1;
    wait_ticks(2 * OS);
    check_eq("glitch_busy_cycles", busy_cycles, OS / 2 * TICK_DIV);
    check_eq("glitch_no_dv", dv_count, 32'd7);
    check_eq("glitch_idle", busy, 32'h0);

    // Reset during data bit 3 of 0xC3 (bits LSB first: 1,1,0,0,...).
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rx_serial = 1'b0;
    wait_ticks(OS / 2);
    @(negedge clk);
    rst       = 1'b1;
    rx_serial = 1'b1;
    check_outputs_zero("midreset");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    wait_ticks(2 * OS);
    check_eq("midreset_no_dv", dv_count, 32'd7);
    exp_q.push_back({1'b0, 1'b0, 8'hC3});
    send_frame(8'hC3, 1'b0, 1'b1);
    wait_dv(8);
    send_bit(1'b1);

    check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
